// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter
//   Round-robin arbiter and transaction sequencer that shares one i2c_master
//   between N_REQ requesters. It latches the winner's {addr,rw} byte and byte
//   count, holds the master start request until the master reports completion,
//   enforces a bus-free gap between transactions, and aborts a transaction that
//   stays in BUSY for TIMEOUT cycles. The abort pulses a soft reset to the master.
//
// Ports
//   clk, rst          system clock, asynchronous active-low reset
//   en                enable; when low no new grant is issued
//   req               per-requester request level
//   req_addr_rw       per-requester {addr[6:0], rw}, slice i = [8i+7:8i]
//   req_cnt           per-requester byte count minus 1
//   gnt, gnt_id       one-hot grant and index of the owner
//   done, err         one-cycle completion / timeout pulse to the owner
//   m_ready           master i_ready
//   m_addr_rw         master data_addr_rw
//   m_data_cnt        master data_cnt
//   m_mode            master mode_i2c
//   m_done            master i2c_done pulse
//   m_rst_n           one-cycle soft reset to the master after a timeout
//   busy              high in every state except IDLE
module i2c_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 1_000_000,
  parameter int GAP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_addr_rw,
  input  logic [8*N_REQ-1:0] req_cnt,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         gnt_id,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic               m_ready,
  output logic [7:0]         m_addr_rw,
  output logic [7:0]         m_data_cnt,
  output logic [1:0]         m_mode,
  input  logic               m_done,
  output logic               m_rst_n,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_GAP
  } state_t;

  localparam int unsigned NR        = N_REQ;
  localparam logic [23:0] WD_LAST   = 24'(TIMEOUT - 1);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES);
  localparam logic [2:0]  LAST_INIT = 3'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [2:0]         last_q, last_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [2:0]         gnt_id_q, gnt_id_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic               m_ready_q, m_ready_d;
  logic [7:0]         m_addr_rw_q, m_addr_rw_d;
  logic [7:0]         m_data_cnt_q, m_data_cnt_d;
  logic [1:0]         m_mode_q, m_mode_d;
  logic               m_rst_n_q, m_rst_n_d;
  logic [23:0]        wd_q, wd_d;
  logic [7:0]         gap_q, gap_d;

  logic               win_found;
  logic [2:0]         win_id;
  logic [N_REQ-1:0]   win_gnt;
  logic [7:0]         win_addr;
  logic [7:0]         win_cnt;

  // Rotating priority: offset k=1 is the requester after the last winner.
  // The inner loop matches the rotated index against constant positions so
  // every req bit and byte slice is selected with a constant index.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_gnt   = '0;
    win_addr  = '0;
    win_cnt   = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (!win_found && req[i] && (i == (32'(last_q) + k) % NR)) begin
          win_found  = 1'b1;
          win_id     = 3'(i);
          win_gnt    = '0;
          win_gnt[i] = 1'b1;
          win_addr   = req_addr_rw[8*i +: 8];
          win_cnt    = req_cnt[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    done_d       = '0;
    err_d        = '0;
    m_ready_d    = m_ready_q;
    m_addr_rw_d  = m_addr_rw_q;
    m_data_cnt_d = m_data_cnt_q;
    m_mode_d     = en ? 2'b10 : 2'b00;
    m_rst_n_d    = 1'b1;
    wd_d         = wd_q;
    gap_d        = gap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en && win_found) begin
          state_d      = ST_BUSY;
          gnt_d        = win_gnt;
          gnt_id_d     = win_id;
          m_addr_rw_d  = win_addr;
          m_data_cnt_d = win_cnt;
          last_d       = win_id;
          m_ready_d    = 1'b1;
          wd_d         = '0;
        end
      end
      ST_BUSY: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (m_done) begin
          done_d    = gnt_q;
          gnt_d     = '0;
          m_ready_d = 1'b0;
          gap_d     = GAP_LOAD;
          state_d   = ST_GAP;
        end else if (wd_q == WD_LAST) begin
          err_d     = gnt_q;
          m_rst_n_d = 1'b0;
          gnt_d     = '0;
          m_ready_d = 1'b0;
          gap_d     = GAP_LOAD;
          state_d   = ST_GAP;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 24'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_q       <= LAST_INIT;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      done_q       <= '0;
      err_q        <= '0;
      m_ready_q    <= 1'b0;
      m_addr_rw_q  <= '0;
      m_data_cnt_q <= '0;
      m_mode_q     <= 2'b00;
      m_rst_n_q    <= 1'b1;
      wd_q         <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      done_q       <= done_d;
      err_q        <= err_d;
      m_ready_q    <= m_ready_d;
      m_addr_rw_q  <= m_addr_rw_d;
      m_data_cnt_q <= m_data_cnt_d;
      m_mode_q     <= m_mode_d;
      m_rst_n_q    <= m_rst_n_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_id     = gnt_id_q;
  assign done       = done_q;
  assign err        = err_q;
  assign m_ready    = m_ready_q;
  assign m_addr_rw  = m_addr_rw_q;
  assign m_data_cnt = m_data_cnt_q;
  assign m_mode     = m_mode_q;
  assign m_rst_n    = m_rst_n_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Testbench for i2c_req_arbiter: transaction-level driver with a cycle-accurate
// expectation model, and a negedge monitor that pops expectations from queues.
module tb_i2c_req_arbiter;
  localparam int N   = 4;
  localparam int TO  = 100;
  localparam int GAP = 3;

  logic         clk;
  logic         rst;
  logic         en;
  logic [3:0]   req;
  logic [31:0]  req_addr_rw;
  logic [31:0]  req_cnt;
  logic [3:0]   gnt;
  logic [2:0]   gnt_id;
  logic [3:0]   done;
  logic [3:0]   err;
  logic         m_ready;
  logic [7:0]   m_addr_rw;
  logic [7:0]   m_data_cnt;
  logic [1:0]   m_mode;
  logic         m_done;
  logic         m_rst_n;
  logic         busy;

  i2c_req_arbiter #(.N_REQ(N), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .req_addr_rw(req_addr_rw), .req_cnt(req_cnt),
    .gnt(gnt), .gnt_id(gnt_id), .done(done), .err(err),
    .m_ready(m_ready), .m_addr_rw(m_addr_rw), .m_data_cnt(m_data_cnt),
    .m_mode(m_mode), .m_done(m_done), .m_rst_n(m_rst_n), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  gnt;
    logic [2:0]  id;
    logic [7:0]  addr;
    logic [7:0]  cnt;
  } grant_t;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  done;
    logic [3:0]  err;
  } comp_t;

  grant_t      exp_gnt_q[$];
  comp_t       exp_comp_q[$];
  int unsigned exp_idle_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an output event, required none (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  logic [3:0] prev_gnt  = '0;
  logic       prev_busy = 1'b0;
  bit         holding   = 1'b0;
  grant_t     hold;

  always @(negedge clk) begin
    grant_t      e;
    comp_t       c;
    int unsigned ic;
    if (!rst) begin
      prev_gnt  = '0;
      prev_busy = 1'b0;
      holding   = 1'b0;
    end else begin
      chk("m_rst_n_vs_err", 64'(m_rst_n), 64'(err == '0));
      if (prev_gnt == '0 && gnt != '0) begin
        if (exp_gnt_q.size() == 0) begin
          fail_evt("unexpected_grant");
        end else begin
          e = exp_gnt_q.pop_front();
          chk("grant_cycle", 64'(cyc), 64'(e.cyc));
          chk("gnt", 64'(gnt), 64'(e.gnt));
          chk("gnt_id", 64'(gnt_id), 64'(e.id));
          chk("m_addr_rw", 64'(m_addr_rw), 64'(e.addr));
          chk("m_data_cnt", 64'(m_data_cnt), 64'(e.cnt));
          chk("grant_ctl", 64'({m_ready, busy, m_mode}), 64'(4'b1110));
          hold    = e;
          holding = 1'b1;
        end
      end else if (gnt != '0 && holding) begin
        chk("busy_hold", 64'({gnt, m_addr_rw, m_data_cnt, m_ready}),
            64'({hold.gnt, hold.addr, hold.cnt, 1'b1}));
      end
      if (done != '0 || err != '0) begin
        if (exp_comp_q.size() == 0) begin
          fail_evt("unexpected_done_err");
        end else begin
          c = exp_comp_q.pop_front();
          chk("completion_cycle", 64'(cyc), 64'(c.cyc));
          chk("done", 64'(done), 64'(c.done));
          chk("err", 64'(err), 64'(c.err));
          chk("release", 64'({gnt, m_ready, busy}), 64'(6'b000001));
        end
        holding = 1'b0;
      end else if (prev_gnt != '0 && gnt == '0) begin
        fail_evt("gnt_dropped_without_completion");
      end
      if (prev_busy && !busy) begin
        if (exp_idle_q.size() == 0) begin
          fail_evt("unexpected_idle");
        end else begin
          ic = exp_idle_q.pop_front();
          chk("idle_cycle", 64'(cyc), 64'(ic));
        end
      end
      prev_gnt  = gnt;
      prev_busy = busy;
    end
  end

  // ---------------- reference model + driver ----------------
  int          m_last;
  int unsigned next_idle;

  function automatic int rr_pick(input int last, input logic [3:0] mask);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (((mask >> idx) & 4'd1) != 4'd0) return idx;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant_regs"}, 64'({gnt, gnt_id, done, err}), 64'(0));
    chk({tag, "_master_regs"}, 64'({m_ready, m_addr_rw, m_data_cnt, m_mode, m_rst_n, busy}),
        64'({1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0}));
  endtask

  function automatic grant_t make_grant(input int w, input logic [31:0] av,
                                        input logic [31:0] cv, input int unsigned at);
    grant_t e;
    e.cyc  = at;
    e.gnt  = 4'(1 << w);
    e.id   = 3'(w);
    e.addr = 8'(av >> (8 * w));
    e.cnt  = 8'(cv >> (8 * w));
    return e;
  endfunction

  // d < 0: master never completes. d >= 0: m_done is high d cycles after the
  // grant cycle (d = 0 is the first BUSY cycle).
  task automatic do_txn(input logic [3:0] mask, input logic [31:0] av, input logic [31:0] cv,
                        input int d, input bit drop_en, input int unsigned extra);
    int          w;
    int unsigned g;
    int unsigned last_c;
    comp_t       c;
    wait_until(next_idle + extra);
    en          = 1'b1;
    req         = mask;
    req_addr_rw = av;
    req_cnt     = cv;
    w      = rr_pick(m_last, mask);
    m_last = w;
    g      = cyc + 1;
    exp_gnt_q.push_back(make_grant(w, av, cv, g));
    if (d >= 0 && d <= TO - 1) begin
      c.cyc  = g + unsigned'(d) + 1;
      c.done = 4'(1 << w);
      c.err  = '0;
    end else begin
      c.cyc  = g + TO;
      c.done = '0;
      c.err  = 4'(1 << w);
    end
    exp_comp_q.push_back(c);
    next_idle = c.cyc + GAP + 1;
    exp_idle_q.push_back(next_idle);
    last_c = c.cyc;
    if (d >= 0 && g + unsigned'(d) > last_c) last_c = g + unsigned'(d);
    tick();
    req         = 4'($urandom);
    req_addr_rw = $urandom;
    req_cnt     = $urandom;
    for (int unsigned cc = g; cc <= last_c; cc++) begin
      m_done = (d >= 0) && (cc == g + unsigned'(d));
      if (cc >= c.cyc) req = '0;
      if (drop_en && cc == g + 1) en = 1'b0;
      tick();
    end
    m_done = 1'b0;
    req    = '0;
  endtask

  task automatic reset_mid_txn(input logic [3:0] mask);
    int w;
    wait_until(next_idle);
    en          = 1'b1;
    req         = mask;
    req_addr_rw = $urandom;
    req_cnt     = $urandom;
    w      = rr_pick(m_last, mask);
    exp_gnt_q.push_back(make_grant(w, req_addr_rw, req_cnt, cyc + 1));
    tick();
    req = 4'($urandom);
    repeat (5) tick();
    #2 rst = 1'b0;
    #1 check_reset_vals("async_reset");
    req    = '0;
    m_last = N - 1;
    tick();
    rst       = 1'b1;
    next_idle = cyc;
  endtask

  initial begin
    int d;
    int r;
    rst = 1'b0; en = 1'b0; req = '0; m_done = 1'b0;
    req_addr_rw = '0; req_cnt = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst       = 1'b1;
    m_last    = N - 1;
    next_idle = cyc;

    // Single request from requester 0 with a fixed address byte and count.
    do_txn(4'b0001, ($urandom & 32'hFFFF_FF00) | 32'h0000_00A0,
           ($urandom & 32'hFFFF_FF00) | 32'h0000_0002, 5, 1'b0, 0);
    do_txn(4'b0001, $urandom, $urandom, 2, 1'b0, 0);

    // All requesting: grants rotate.
    for (int i = 0; i < 5; i++) do_txn(4'b1111, $urandom, $urandom, $urandom_range(0, 8), 1'b0, 0);

    // Watchdog abort, done on the terminal cycle, and done just after abort.
    do_txn(4'b0100, $urandom, $urandom, -1, 1'b0, 0);
    do_txn(4'b1111, $urandom, $urandom, TO - 1, 1'b0, 0);
    do_txn(4'b1010, $urandom, $urandom, TO, 1'b0, 1);

    // Enable low blocks the grant; raising it grants on the next edge.
    wait_until(next_idle);
    en  = 1'b0;
    req = 4'b0100;
    repeat (6) tick();
    chk("en_low_mode", 64'(m_mode), 64'(2'b00));
    chk("en_low_no_grant", 64'({gnt, busy}), 64'(0));
    do_txn(4'b0100, $urandom, $urandom, 7, 1'b0, 0);

    // Randomised traffic, including enable drops while busy.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0)      d = -1;
      else if (r == 1) d = TO - 1;
      else if (r == 2) d = TO;
      else             d = $urandom_range(0, 12);
      do_txn(4'($urandom_range(1, 15)), $urandom, $urandom, d,
             1'($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    // Reset in the middle of a transaction, then rotation restarts at 0.
    reset_mid_txn(4'b0110);
    for (int i = 0; i < 5; i++) do_txn(4'b1111, $urandom, $urandom, $urandom_range(0, 4), 1'b0, 0);

    wait_until(next_idle + 4);
    chk("pending_grants", 64'(exp_gnt_q.size()), 64'(0));
    chk("pending_completions", 64'(exp_comp_q.size()), 64'(0));
    chk("pending_idles", 64'(exp_idle_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule
